// File: rtl/lt24_pixel_writer.sv
// Pixel-interface responder that serialises accepted pixels into LT24 (ILI9341) 16-bit bus writes.
// Pixels that continue a raster run skip the address window and send only the data word.
module lt24_pixel_writer #(
  parameter int unsigned LCD_WIDTH      = 240,
  parameter int unsigned LCD_HEIGHT     = 320,
  parameter int unsigned WR_LOW_CYCLES  = 2,
  parameter int unsigned WR_HIGH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        resetApp_n,
  input  logic [7:0]  xAddr,
  input  logic [8:0]  yAddr,
  input  logic [15:0] pixelData,
  input  logic        pixelWrite,
  output logic        pixelReady,
  output logic        LT24Wr_n,
  output logic        LT24Rd_n,
  output logic        LT24CS_n,
  output logic        LT24RS,
  output logic [15:0] LT24Data
);

  localparam int unsigned WORD_CYCLES = WR_LOW_CYCLES + WR_HIGH_CYCLES;
  localparam int unsigned CW          = (WORD_CYCLES > 1) ? $clog2(WORD_CYCLES) : 1;
  localparam int unsigned ADDR_WORDS  = 11;
  localparam logic [15:0] X_END       = 16'(LCD_WIDTH - 1);
  localparam logic [15:0] Y_END       = 16'(LCD_HEIGHT - 1);

  typedef enum logic [2:0] {
    sInit,
    sIdle,
    sCheck,
    sAddr,
    sData,
    sDone
  } stateT;

  stateT         state;
  stateT         nextState;
  logic [CW-1:0] cycCnt;
  logic [3:0]    wordIdx;
  logic          wordDone;
  logic          addrLast;
  logic [7:0]    xLat;
  logic [8:0]    yLat;
  logic [15:0]   dataLat;
  logic [7:0]    expX;
  logic [8:0]    expY;
  logic          expValid;
  logic [15:0]   xExt;
  logic [15:0]   yExt;
  logic          outOfRange;
  logic          addrMatch;

  assign xExt       = {8'h00, xLat};
  assign yExt       = {7'h00, yLat};
  assign outOfRange = (xExt >= 16'(LCD_WIDTH)) || (yExt >= 16'(LCD_HEIGHT));
  assign addrMatch  = expValid && (xLat == expX) && (yLat == expY);
  assign wordDone   = (cycCnt == CW'(WORD_CYCLES - 1));
  assign addrLast   = (wordIdx == 4'(ADDR_WORDS - 1));

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      state <= sInit;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    unique case (state)
      sInit:  nextState = sIdle;
      sIdle:  if (pixelWrite) nextState = sCheck;
      sCheck: begin
        if (outOfRange)      nextState = sIdle;
        else if (addrMatch)  nextState = sData;
        else                 nextState = sAddr;
      end
      sAddr:  if (wordDone && addrLast) nextState = sData;
      sData:  if (wordDone) nextState = sDone;
      sDone:  nextState = sIdle;
      default: nextState = sInit;
    endcase
  end

  // Word sequencer: cycCnt walks the low+high strobe phases, wordIdx the address words.
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      cycCnt  <= '0;
      wordIdx <= '0;
    end else if (state == sAddr || state == sData) begin
      if (wordDone) begin
        cycCnt  <= '0;
        wordIdx <= (state == sAddr && !addrLast) ? wordIdx + 4'd1 : '0;
      end else begin
        cycCnt <= cycCnt + CW'(1);
      end
    end else begin
      cycCnt  <= '0;
      wordIdx <= '0;
    end
  end

  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      xLat    <= '0;
      yLat    <= '0;
      dataLat <= '0;
    end else if (state == sIdle && pixelWrite) begin
      xLat    <= xAddr;
      yLat    <= yAddr;
      dataLat <= pixelData;
    end
  end

  // Mirrors the panel's auto-increment inside the full-screen window.
  always_ff @(posedge clock or negedge resetApp_n) begin
    if (!resetApp_n) begin
      expX     <= '0;
      expY     <= '0;
      expValid <= 1'b0;
    end else if (state == sDone) begin
      expValid <= 1'b1;
      if (xExt == X_END) begin
        expX <= '0;
        expY <= (yExt == Y_END) ? '0 : yLat + 9'd1;
      end else begin
        expX <= xLat + 8'd1;
        expY <= yLat;
      end
    end
  end

  always_comb begin
    pixelReady = (state == sIdle);
    LT24Rd_n   = 1'b1;
    LT24CS_n   = 1'b1;
    LT24Wr_n   = 1'b1;
    LT24RS     = 1'b1;
    LT24Data   = '0;
    if (state == sAddr || state == sData) begin
      LT24CS_n = 1'b0;
      LT24Wr_n = (cycCnt < CW'(WR_LOW_CYCLES)) ? 1'b0 : 1'b1;
    end
    if (state == sData) begin
      LT24Data = dataLat;
    end else if (state == sAddr) begin
      unique case (wordIdx)
        4'd0:    begin LT24RS = 1'b0; LT24Data = 16'h002A; end
        4'd1:    LT24Data = {8'h00, xExt[15:8]};
        4'd2:    LT24Data = {8'h00, xExt[7:0]};
        4'd3:    LT24Data = {8'h00, X_END[15:8]};
        4'd4:    LT24Data = {8'h00, X_END[7:0]};
        4'd5:    begin LT24RS = 1'b0; LT24Data = 16'h002B; end
        4'd6:    LT24Data = {8'h00, yExt[15:8]};
        4'd7:    LT24Data = {8'h00, yExt[7:0]};
        4'd8:    LT24Data = {8'h00, Y_END[15:8]};
        4'd9:    LT24Data = {8'h00, Y_END[7:0]};
        4'd10:   begin LT24RS = 1'b0; LT24Data = 16'h002C; end
        default: LT24Data = '0;
      endcase
    end
  end

endmodule
